frame_rd_fifo: RTL and testbench

Read-side elastic buffer that sits directly downstream of the frame buffer controller and memory interface. It throttles the controller's active-low read enable so that reads in flight never overrun local storage. It captures returning read data into a FIFO and delivers one pixel per request to the display pipeline, counting pixels per frame. It flags overflow and underflow conditions for debug.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/sync_fifo_ram.sv | 45 ++++
 rtl/frame_rd_fifo.sv | 172 +++++++++++++++++
 tb/tb_frame_rd_fifo.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
// fb_pkg: shared constants for the frame buffer read path.
//   - Active-low / active-high assert levels.
//   - Frame geometry (640 x 480) and the derived pixel count per frame.
//   - Read-side FSM state type.
package fb_pkg;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
`timescale 1ns/1ps
// sync_fifo_ram: simple dual-port register array backing the read FIFO.
//   clk    : clock
//   reset  : synchronous active-low reset (clears the read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata holds its value when low
//   raddr  : read address
//   rdata  : registered read data, valid the cycle after re
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-cycle write to raddr returns the old word,
    // which is what a full FIFO doing push+pop needs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_rd_fifo.sv
`timescale 1ns/1ps
// frame_rd_fifo: read-side elastic buffer between the frame buffer
// controller / memory interface and the display pipeline.
//   clk, reset       : clock, synchronous active-low reset
//   start            : pulse arming a frame (ignored outside IDLE)
//   fb_read_req      : controller read request (observed)
//   avl_ready        : memory ready (observed); accepted read = req && ready
//   avl_rdata        : returning read data
//   avl_rdata_valid  : returning read data valid; pushed into the FIFO
//   fb_rd_en         : active-low read enable back to the controller
//   pix_req          : display pixel request
//   pix_data         : pixel output, 1-cycle pop latency
//   pix_valid        : one-cycle strobe per delivered pixel
//   frame_end        : pulses with the last pixel of a frame
//   level            : FIFO occupancy
//   overflow         : sticky, push dropped while full
//   underflow        : sticky, pix_req while streaming with empty FIFO
module frame_rd_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_AW      = 6,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned PREFILL      = 32,
    parameter int unsigned FRAME_PIX    = fb_pkg::FRAME_PIX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fb_read_req,
    input  logic                  avl_ready,
    input  logic [DATA_WIDTH-1:0] avl_rdata,
    input  logic                  avl_rdata_valid,
    output logic                  fb_rd_en,
    input  logic                  pix_req,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  frame_end,
    output logic [FIFO_AW:0]      level,
    output logic                  overflow,
    output logic                  underflow
);

    import fb_pkg::*;

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int unsigned SUM_W = FIFO_AW + 3;

    rd_state_t           state;
    logic [FIFO_AW-1:0]  wptr;
    logic [FIFO_AW-1:0]  rptr;
    logic [FIFO_AW:0]    inflight;
    logic [CNT_W-1:0]    pix_cnt;

    logic                accepted;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                last_pix;
    logic                rd_ok;
    logic [SUM_W-1:0]    occ_sum;

    always_comb begin
        accepted   = fb_read_req && avl_ready;
        fifo_full  = (level == (FIFO_AW+1)'(DEPTH));
        fifo_empty = (level == '0);
        pop        = (state == ST_STREAM) && pix_req && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push       = avl_rdata_valid && (!fifo_full || pop);
        last_pix   = (pix_cnt == CNT_W'(FRAME_PIX - 1));
        // +2 leaves room for the request already in the controller's
        // registered pipeline plus the one issued while fb_rd_en updates.
        occ_sum    = SUM_W'(level) + SUM_W'(inflight) + SUM_W'(2);
        rd_ok      = (state != ST_IDLE)
                  && (occ_sum <= SUM_W'(DEPTH))
                  && (inflight < (FIFO_AW+1)'(MAX_INFLIGHT));
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (FIFO_AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wptr),
        .wdata (avl_rdata),
        .re    (pop),
        .raddr (rptr),
        .rdata (pix_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            inflight  <= '0;
            pix_cnt   <= '0;
            fb_rd_en  <= DEASSERT_L;
            pix_valid <= DEASSERT_H;
            frame_end <= DEASSERT_H;
            overflow  <= DEASSERT_H;
            underflow <= DEASSERT_H;
        end else begin
            if (push) begin
                wptr <= wptr + FIFO_AW'(1);
            end
            if (pop) begin
                rptr <= rptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase

            // Returns still arriving after a reset must not wrap below zero.
            case ({accepted, avl_rdata_valid})
                2'b10: begin
                    if (inflight != '1) begin
                        inflight <= inflight + (FIFO_AW+1)'(1);
                    end
                end
                2'b01: begin
                    if (inflight != '0) begin
                        inflight <= inflight - (FIFO_AW+1)'(1);
                    end
                end
                default: inflight <= inflight;
            endcase

            if (avl_rdata_valid && fifo_full && !pop) begin
                overflow <= ASSERT_H;
            end
            if ((state == ST_STREAM) && pix_req && fifo_empty) begin
                underflow <= ASSERT_H;
            end

            fb_rd_en  <= rd_ok ? ASSERT_L : DEASSERT_L;
            pix_valid <= pop;
            frame_end <= pop && last_pix;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_PREFILL;
                        pix_cnt <= '0;
                    end
                end
                ST_PREFILL: begin
                    if (level >= (FIFO_AW+1)'(PREFILL)) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pop) begin
                        if (last_pix) begin
                            pix_cnt <= '0;
                            state   <= ST_PREFILL;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rd_fifo.sv
`timescale 1ns/1ps
// tb_frame_rd_fifo: scoreboard bench. The memory model pushes every word it
// returns (while out of reset) into exp_q; a negedge monitor pops and checks
// each delivered pixel, plus frame_end placement and the re-prefill gap.
module tb_frame_rd_fifo;

    import fb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int MAXI  = 8;
    localparam int PRE   = 32;
    localparam int FP    = 100;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          fb_read_req;
    logic          avl_ready;
    logic [DW-1:0] avl_rdata;
    logic          avl_rdata_valid;
    logic          fb_rd_en;
    logic          pix_req;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          frame_end;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    frame_rd_fifo #(
        .DATA_WIDTH   (DW),
        .FIFO_AW      (AW),
        .MAX_INFLIGHT (MAXI),
        .PREFILL      (PRE),
        .FRAME_PIX    (FP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fb_read_req     (fb_read_req),
        .avl_ready       (avl_ready),
        .avl_rdata       (avl_rdata),
        .avl_rdata_valid (avl_rdata_valid),
        .fb_rd_en        (fb_rd_en),
        .pix_req         (pix_req),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .frame_end       (frame_end),
        .level           (level),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q [$];
    int            ret_cyc [$];
    logic [DW-1:0] ret_dat [$];
    int            cyc = 0;
    int            rd_seq = 0;
    logic          ctrl_en = 1'b0;
    int            force_n = 0;
    int            force_idx = 0;

    int            pcount = 0;
    int            max_level = 0;
    logic          first_chk = 1'b0;
    logic          gap_chk = 1'b0;
    logic [DW-1:0] last_pix = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory + controller model: 5-cycle read latency, avl_ready always high,
    // controller requests whenever fb_rd_en is asserted and ctrl_en is set.
    initial begin
        logic acc;
        fb_read_req     = 1'b0;
        avl_ready       = 1'b1;
        avl_rdata       = '0;
        avl_rdata_valid = 1'b0;
        forever begin
            @(posedge clk);
            acc = fb_read_req && avl_ready;
            #1;
            if (acc) begin
                ret_cyc.push_back(cyc + 4);
                ret_dat.push_back(32'h1000_0000 + rd_seq);
                rd_seq++;
            end
            avl_rdata_valid = 1'b0;
            if (force_n > 0) begin
                avl_rdata_valid = 1'b1;
                avl_rdata       = 32'hF000_0000 + force_idx;
                // FIFO starts empty, so only the first DEPTH forced words fit.
                if (reset && force_idx < DEPTH) exp_q.push_back(avl_rdata);
                force_idx++;
                force_n--;
            end else if (ret_cyc.size() > 0 && ret_cyc[0] == cyc) begin
                void'(ret_cyc.pop_front());
                avl_rdata_valid = 1'b1;
                avl_rdata       = ret_dat.pop_front();
                if (reset) exp_q.push_back(avl_rdata);
            end
            fb_read_req = ctrl_en && (fb_rd_en == ASSERT_L);
        end
    end

    // Monitor
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (int'(level) > max_level) max_level = int'(level);
                if (gap_chk) begin
                    n_vec++;
                    if (pix_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL refill_gap: pix_valid %b expected 0 after frame_end", pix_valid);
                    end
                    gap_chk = 1'b0;
                end
                if (pix_valid) begin
                    pcount++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL pix_data: got %0h with no word expected", pix_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (pix_data !== e) begin
                            n_err++;
                            $display("FAIL pix_data #%0d: got %0h expected %0h", pcount, pix_data, e);
                        end
                    end
                    n_vec++;
                    if (frame_end !== ((pcount % FP) == 0)) begin
                        n_err++;
                        $display("FAIL frame_end at pixel %0d: got %b expected %b", pcount, frame_end, (pcount % FP) == 0);
                    end
                    if (first_chk) begin
                        n_vec++;
                        if (max_level < PRE) begin
                            n_err++;
                            $display("FAIL prefill: first pixel with max level %0d expected >= %0d", max_level, PRE);
                        end
                        first_chk = 1'b0;
                    end
                    if (frame_end) gap_chk = 1'b1;
                    last_pix = pix_data;
                end
            end
        end
    end

    initial begin
        int max_sum;
        int max_inf;
        int cur_inf;
        int saw_deassert;
        int budget;
        reset   = 1'b0;
        start   = 1'b0;
        pix_req = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_fb_rd_en", fb_rd_en, 1);
        chk("rst_level", level, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_pix_data", pix_data, 0);
        reset = 1'b1;
        repeat (5) tick();
        chk("idle_fb_rd_en", fb_rd_en, 1);

        // Throttling: fill with no pops
        ctrl_en = 1'b1;
        start = 1'b1;
        first_chk = 1'b1;
        tick();
        start = 1'b0;
        max_sum = 0;
        max_inf = 0;
        saw_deassert = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            cur_inf = ret_cyc.size() + ((force_n == 0) ? int'(avl_rdata_valid) : 0);
            if (int'(level) + cur_inf > max_sum) max_sum = int'(level) + cur_inf;
            if (cur_inf > max_inf) max_inf = cur_inf;
            if (i > 20 && fb_rd_en == DEASSERT_L) saw_deassert = 1;
        end
        chk("thr_sum_le_depth", (max_sum <= DEPTH), 1);
        chk("thr_inflight_le_max", (max_inf <= MAXI), 1);
        chk("thr_rd_en_deasserted", saw_deassert, 1);
        chk("thr_level_settled", (level >= 63 && level <= 64), 1);
        chk("thr_overflow", overflow, 0);

        // Streaming across two frame boundaries
        pix_req = 1'b1;
        repeat (250) tick();
        chk("str_underflow", underflow, 0);
        chk("str_throughput", (pcount >= 200), 1);

        // Underflow: stop reads 10 pixels into a frame, keep requesting
        budget = 300;
        while ((pcount % FP) != 10 && budget > 0) begin
            tick();
            budget--;
        end
        chk("unf_sync_timeout", (budget > 0), 1);
        ctrl_en = 1'b0;
        budget = 200;
        while (underflow !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        chk("unf_set", underflow, 1);
        chk("unf_pix_valid", pix_valid, 0);
        repeat (3) tick();
        chk("unf_sticky", underflow, 1);
        chk("unf_pix_data_held", pix_data, last_pix);
        chk("unf_all_delivered", exp_q.size(), 0);

        // Overflow: 65 forced pushes, no pops
        pix_req = 1'b0;
        force_idx = 0;
        force_n = 65;
        repeat (70) tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 64);
        chk("ovf_rd_en", fb_rd_en, 1);
        pix_req = 1'b1;
        repeat (20) tick();
        chk("ovf_sticky", overflow, 1);

        // Mid-frame reset
        reset = 1'b0;
        exp_q.delete();
        tick();
        pcount = 0;
        max_level = 0;
        gap_chk = 1'b0;
        first_chk = 1'b0;
        chk("mrst_fb_rd_en", fb_rd_en, 1);
        chk("mrst_level", level, 0);
        chk("mrst_pix_valid", pix_valid, 0);
        chk("mrst_pix_data", pix_data, 0);
        chk("mrst_frame_end", frame_end, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_underflow", underflow, 0);
        reset = 1'b1;
        tick();

        // Restart with continuous pix_req from start
        ctrl_en = 1'b1;
        start = 1'b1;
        first_chk = 1'b1;
        tick();
        start = 1'b0;
        repeat (200) tick();
        chk("rst2_first_pixel_seen", first_chk, 0);
        chk("rst2_frame_crossed", (pcount > FP), 1);
        chk("rst2_underflow", underflow, 0);
        chk("rst2_overflow", overflow, 0);

        ctrl_en = 1'b0;
        pix_req = 1'b0;
        repeat (10) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
